// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_reg: valid/ready pipeline stage, optional two-entry skid buffer|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int DATA_W       = 64,
  parameter bit SKID         = 1'b1,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        level_o
);

  logic              push;
  logic              pop;
  logic              main_v_q;
  logic              main_v_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic              skid_v;

  assign push = in_valid_i & in_ready_o;
  assign pop  = main_v_q & out_ready_i;

  generate
    if (SKID) begin : g_skid
      logic              skid_v_q;
      logic              skid_v_d;
      logic [DATA_W-1:0] skid_data_q;
      logic [DATA_W-1:0] skid_data_d;

      // Ready depends only on skid occupancy, so it never sees out_ready_i.
      assign in_ready_o = ~skid_v_q;
      assign skid_v     = skid_v_q;

      always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end else if (skid_v_q) begin
          if (pop) begin
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
          end
        end else if (main_v_q) begin
          case ({push, pop})
            2'b11:   main_data_d = in_data_i;
            2'b10: begin
              skid_v_d    = 1'b1;
              skid_data_d = in_data_i;
            end
            2'b01:   main_v_d = 1'b0;
            default: ;
          endcase
        end else if (push) begin
          main_v_d    = 1'b1;
          main_data_d = in_data_i;
        end
      end

      always_ff @(posedge clk_i) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
        if (rst_i) begin
          main_v_q <= 1'b0;
          skid_v_q <= 1'b0;
        end else begin
          main_v_q <= main_v_d;
          skid_v_q <= skid_v_d;
        end
      end
    end else begin : g_single
      assign in_ready_o = ~main_v_q | out_ready_i;
      assign skid_v     = 1'b0;

      always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        if (flush_i) begin
          main_v_d = 1'b0;
        end else if (push) begin
          main_v_d    = 1'b1;
          main_data_d = in_data_i;
        end else if (pop) begin
          main_v_d = 1'b0;
        end
      end

      always_ff @(posedge clk_i) begin
        main_data_q <= main_data_d;
        if (rst_i) begin
          main_v_q <= 1'b0;
        end else begin
          main_v_q <= main_v_d;
        end
      end
    end
  endgenerate

  generate
    if (ZERO_INVALID) begin : g_zero
      assign out_data_o = main_data_q & {DATA_W{main_v_q}};
    end else begin : g_raw
      assign out_data_o = main_data_q;
    end
  endgenerate

  assign out_valid_o = main_v_q;
  assign level_o     = {1'b0, main_v_q} + {1'b0, skid_v};

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_reg: directed table plus random queue-model checking       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_reg;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst, flush, iv, ordy;
  logic [DW-1:0] din;

  logic          a_rdy, a_v, b_rdy, b_v, c_rdy, c_v;
  logic [DW-1:0] a_d, b_d, c_d;
  logic [1:0]    a_l, b_l, c_l;

  always #5 clk = ~clk;

  // a: SKID=1 ZERO_INVALID=1, b: SKID=0, c: SKID=1 ZERO_INVALID=0
  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .ZERO_INVALID(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(a_rdy),
    .in_data_i(din), .out_valid_o(a_v), .out_ready_i(ordy), .out_data_o(a_d), .level_o(a_l));
  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .ZERO_INVALID(1'b1)) u_s0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(b_rdy),
    .in_data_i(din), .out_valid_o(b_v), .out_ready_i(ordy), .out_data_o(b_d), .level_o(b_l));
  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .ZERO_INVALID(1'b0)) u_z0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(c_rdy),
    .in_data_i(din), .out_valid_o(c_v), .out_ready_i(ordy), .out_data_o(c_d), .level_o(c_l));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference queues: q1 models the skid stage, q0 the single-register stage.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];

  always @(posedge clk) begin
    bit r1, r0, p1, p0;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || ordy;
    p1 = (q1.size() > 0) && ordy;
    p0 = (q0.size() > 0) && ordy;
    if (rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (p1) void'(q1.pop_front());
      if (iv && r1) q1.push_back(din);
      if (p0) void'(q0.pop_front());
      if (iv && r0) q0.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [DW-1:0] e1, e0;
      e1 = (q1.size() > 0) ? q1[0] : '0;
      e0 = (q0.size() > 0) ? q0[0] : '0;
      check("m1_valid", DW'(a_v), DW'(q1.size() > 0));
      check("m1_ready", DW'(a_rdy), DW'(q1.size() < 2));
      check("m1_level", DW'(a_l), DW'(q1.size()));
      check("m1_data", a_d, e1);
      check("m0_valid", DW'(b_v), DW'(q0.size() > 0));
      check("m0_ready", DW'(b_rdy), DW'((q0.size() == 0) || ordy));
      check("m0_level", DW'(b_l), DW'(q0.size()));
      check("m0_data", b_d, e0);
      check("mz_valid", DW'(c_v), DW'(q1.size() > 0));
      check("mz_ready", DW'(c_rdy), DW'(q1.size() < 2));
      check("mz_level", DW'(c_l), DW'(q1.size()));
      if (q1.size() > 0) check("mz_data", c_d, e1);
    end
  end

  typedef struct {
    logic          rst, flush, iv;
    logic [DW-1:0] din;
    logic          ordy;
    logic          ev, er;
    logic [1:0]    el;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic r, input logic f, input logic v, input logic [DW-1:0] d,
                      input logic o, input logic ev, input logic er, input logic [1:0] el,
                      input logic [DW-1:0] ed);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = v; t.din = d; t.ordy = o;
    t.ev = ev; t.er = er; t.el = el; t.ed = ed;
    tbl.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; din = '0;

    //   rst flush iv  din                     ordy  ev er  el  ed
    addv(1, 0, 0, 64'h0,                     0,    0, 1, 0, 64'h0);
    addv(0, 0, 1, 64'h0000_1000_0000_0013,   1,    1, 1, 1, 64'h0000_1000_0000_0013);
    addv(0, 0, 0, 64'h0,                     1,    0, 1, 0, 64'h0);
    addv(0, 0, 1, 64'hA,                     0,    1, 1, 1, 64'hA);
    addv(0, 0, 1, 64'hB,                     0,    1, 0, 2, 64'hA);
    addv(0, 0, 1, 64'hC,                     0,    1, 0, 2, 64'hA);
    addv(0, 0, 1, 64'hC,                     1,    1, 1, 1, 64'hB);
    addv(0, 0, 1, 64'hC,                     1,    1, 1, 1, 64'hC);
    addv(0, 0, 0, 64'h0,                     1,    0, 1, 0, 64'h0);
    addv(0, 0, 1, 64'hD,                     0,    1, 1, 1, 64'hD);
    addv(0, 0, 1, 64'hE,                     0,    1, 0, 2, 64'hD);
    addv(0, 1, 1, 64'hF,                     0,    0, 1, 0, 64'h0);
    addv(0, 0, 0, 64'h0,                     1,    0, 1, 0, 64'h0);
    addv(0, 0, 1, 64'h11,                    0,    1, 1, 1, 64'h11);
    addv(0, 1, 0, 64'h0,                     1,    0, 1, 0, 64'h0);
    addv(0, 0, 1, 64'h22,                    0,    1, 1, 1, 64'h22);
    addv(0, 0, 1, 64'h33,                    0,    1, 0, 2, 64'h22);
    addv(1, 0, 1, 64'h44,                    1,    0, 1, 0, 64'h0);
    addv(0, 0, 0, 64'h55,                    1,    0, 1, 0, 64'h0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush = tbl[i].flush; iv = tbl[i].iv;
      din = tbl[i].din; ordy = tbl[i].ordy;
      tick();
      chk_en = 1'b1;
      check($sformatf("tbl%0d_valid", i), DW'(a_v), DW'(tbl[i].ev));
      check($sformatf("tbl%0d_ready", i), DW'(a_rdy), DW'(tbl[i].er));
      check($sformatf("tbl%0d_level", i), DW'(a_l), DW'(tbl[i].el));
      check($sformatf("tbl%0d_data", i), a_d, tbl[i].ed);
    end
    rst = 1'b0; flush = 1'b0;

    // Back-to-back stream through both stage flavours.
    for (int k = 1; k <= 8; k++) begin
      iv = 1'b1; din = DW'(k); ordy = 1'b1;
      tick();
      check("stream_skid_valid", DW'(a_v), DW'(1));
      check("stream_skid_data", a_d, DW'(k));
      check("stream_skid_ready", DW'(a_rdy), DW'(1));
      check("stream_single_data", b_d, DW'(k));
      check("stream_single_ready", DW'(b_rdy), DW'(1));
    end
    iv = 1'b0;
    tick();
    check("stream_drained", DW'(a_l), DW'(0));

    // Raw vs zeroed payload after the entry drains.
    iv = 1'b1; din = 64'hDEAD; ordy = 1'b1;
    tick();
    check("zi_loaded", c_d, 64'hDEAD);
    iv = 1'b0;
    tick();
    check("zi_raw_valid", DW'(c_v), DW'(0));
    check("zi_raw_data", c_d, 64'hDEAD);
    check("zi_zero_data", a_d, 64'h0);

    // Random traffic, checked cycle by cycle against the queue models.
    for (int k = 0; k < 10000; k++) begin
      iv    = ($urandom_range(99) < 70);
      ordy  = ($urandom_range(99) < 60);
      flush = ($urandom_range(99) < 3);
      rst   = ($urandom_range(999) < 3);
      din   = {$urandom, $urandom};
      tick();
      if (rst) check("rnd_reset_level", DW'(a_l), DW'(0));
    end
    rst = 1'b0; flush = 1'b0; iv = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic valid/ready pipeline stage register for the core pipeline. It is the parametrised successor of the fixed IF/ID latch and is meant for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width payload.
- Optional two-entry skid mode gives full throughput with a registered ready.
- Synchronous flush kills in-flight entries on branch redirect.
- Output payload is optionally zeroed while invalid.

Parameters:
DATA_W, 64, payload width in bits (e.g. inst 32 + pc 32).
SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready.
ZERO_INVALID, 1, 1 = out_data_o forced to 0 when out_valid_o = 0; 0 = raw register contents.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
flush_i  input  1  synchronous kill of all held entries and of the same-cycle input
in_valid_i  input  1  upstream valid
in_ready_o  output  1  stage can accept
in_data_i  input  DATA_W  upstream payload
out_valid_o  output  1  downstream valid
out_ready_i  input  1  downstream ready
out_data_o  output  DATA_W  downstream payload
level_o  output  2  entries held: 0..2 (SKID=1), 0..1 (SKID=0)

Behaviour:
- Handshake definitions: push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- Reset (rst_i=1 at an edge): main_v = 0, skid_v = 0. Outputs after reset: out_valid_o = 0, level_o = 0, in_ready_o = 1, out_data_o = 0 (when ZERO_INVALID=1).
- Payload registers are not reset; only the valid bits are.
- Latency: one cycle, push at edge N gives out_valid_o = 1 after edge N.
- Order is strictly preserved; there is no bypass from in_data_i to out_data_o.
- Held data is stable: out_valid_o = 1 with out_ready_i = 0 keeps out_data_o and out_valid_o unchanged.
- out_valid_o = main_v. out_data_o = main_data, ANDed with {DATA_W{main_v}} when ZERO_INVALID=1.
- level_o = main_v + skid_v.
- SKID=0:
  - in_ready_o = ~main_v | out_ready_i (combinational).
  - On push: main_data <= in_data_i, main_v <= 1.
  - Else on pop: main_v <= 0.
- SKID=1 (states EMPTY, ONE, TWO):
  - in_ready_o = ~skid_v, a pure register output with no path from out_ready_i.
  - EMPTY: push -> ONE, main <= in.
  - ONE, push & pop -> ONE, main <= in.
  - ONE, push & ~pop -> TWO, skid <= in.
  - ONE, ~push & pop -> EMPTY.
  - ONE, neither -> ONE, hold.
  - TWO: in_ready_o = 0, so no push. pop -> ONE with main <= skid, skid_v <= 0. No pop -> hold.
- Flush:
  - flush_i=1 at an edge forces main_v <= 0 and skid_v <= 0 regardless of push/pop.
  - An input handshaking in the same cycle is discarded.
  - A pop in the same cycle still completes, since downstream sampled it.
  - in_ready_o is not gated by flush_i.
- Priority: rst_i > flush_i > push/pop.
- Reset mid-operation: all entries lost; no output pulse is generated.
- Illegal-input tolerance: in_valid_i may drop without a handshake; no state change results.

Test Plan:
1. Reset, then in_valid_i=1, in_data_i=0x0000_1000_0000_0013, out_ready_i=1 -> one cycle later out_valid_o=1, out_data_o=0x0000_1000_0000_0013, level_o=1; in_ready_o stays 1.
2. Back-to-back stream of 8 payloads 1..8 with out_ready_i=1 (SKID=1 and SKID=0) -> outputs 1..8 on consecutive cycles, no bubbles, in_ready_o constant 1.
3. SKID=1: push A, B, C with out_ready_i=0 -> level_o goes 1, 2. in_ready_o=0 after B, so C is not accepted and its data is held by upstream. Then out_ready_i=1 -> A, B, C emerge in order and level_o returns to 0.
4. SKID=1 holding 2 entries: flush_i=1 together with in_valid_i=1 -> next cycle out_valid_o=0, level_o=0, out_data_o=0 (ZERO_INVALID=1), and the flushed input never appears.
5. ZERO_INVALID=0 after draining payload 0xDEAD -> out_valid_o=0 while out_data_o=0xDEAD. ZERO_INVALID=1 -> out_data_o=0.
6. Random valid/ready/flush for 10k cycles against a queue model -> no loss, duplication or reordering, except entries flushed per the flush rules. Also asserted: out_data_o stable while stalled, in_ready_o under SKID=1 has no combinational dependence on out_ready_i, and rst_i mid-stream gives level_o=0 next cycle.
